hpdl1414_scan_driver: RTL and testbench
=======================================

# hpdl1414_scan_driver

Downstream consumer of the 16-entry display buffer. It cycles through buffer addresses 0–15 and reads each character over the buffer's registered read port. It sanitises each character to the HPDL-1414 7-bit set and writes it into one of four daisy-placed HPDL-1414 displays with correctly timed address, data and active-low WR strobes. It also generates the caret blink strobe that the buffer uses to flash the current write position.

## Interface
Parameters:
- SETUP_CYCLES, 2: cycles address/data are stable before WR falls (min 1)
- STROBE_CYCLES, 4: cycles WR is held low (min 1)
- HOLD_CYCLES, 2: cycles address/data are held after WR rises (min 1)
- FRAME_GAP, 1024: idle cycles between frames (min 1)
- BLINK_FRAMES, 16: frames per caret-strobe half period (min 1)

Ports (one clock; reset is asynchronous and active-high):
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  scanning allowed
- o_read_enable  out  1  buffer read request
- o_read_address  out  4  buffer index being read
- i_read_data  in  8  buffer output; valid one cycle after o_read_enable
- o_caret_strobe  out  1  to buffer caret input; 1 = real character shown
- o_hpdl_data  out  7  D6..D0 to all displays
- o_hpdl_addr  out  2  A1..A0 digit select to all displays
- o_hpdl_wr_n  out  4  per-display WR, active low
- o_frame_done  out  1  one-cycle pulse at end of each 16-char frame

## Operation
- States: IDLE → READ → CAPTURE → SETUP → STROBE → HOLD → (READ of next index | IDLE after index 15).
- IDLE: the gap counter counts up from 0 on entry. When the count reaches FRAME_GAP-1 and i_enable=1, go to READ with index 0. If i_enable=0, the counter holds at its terminal value and the block waits.
- READ (1 cycle): o_read_enable=1, o_read_address=index.
- CAPTURE (1 cycle): i_read_data is sampled at the exit edge and sanitised:
  - 0x20–0x5F: pass bits [6:0].
  - 0x61–0x7A: subtract 0x20 (lower→upper).
  - All others, including 0x60 and 0x7B–0xFF: 0x20 (space).
- SETUP/STROBE/HOLD last SETUP_CYCLES, STROBE_CYCLES and HOLD_CYCLES respectively. o_hpdl_data and o_hpdl_addr are stable across all three. Only during STROBE is o_hpdl_wr_n[chip] low; all other wr_n bits stay high.
- Mapping: chip = index[3:2]; digit = 3 − index[1:0] (digit 0 is rightmost). Example: index 0 → chip 0 addr 3; index 15 → chip 3 addr 0.
- End of HOLD for index 15: o_frame_done=1 for that one cycle, index wraps to 0, go to IDLE.
- i_enable=0 mid-frame: finish the current character through HOLD, then go to IDLE. A strobe is never truncated. Index resets to 0.
- Caret: the frame counter increments on each o_frame_done. At BLINK_FRAMES-1 it wraps to 0 and toggles o_caret_strobe.

## Timing
- Reset values: o_read_enable=0, o_read_address=0, o_hpdl_data=0, o_hpdl_addr=0, o_hpdl_wr_n=4'hF, o_frame_done=0, o_caret_strobe=1. State is IDLE and all counters are 0.
- Reset mid-strobe: wr_n goes high asynchronously. The next frame restarts at index 0 after a full FRAME_GAP.
- Read latency is 1 cycle: the address is presented in READ and the data is used at the end of CAPTURE.
- Per character: 2+SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES cycles (10 at defaults).
- Frame period: 16×that + FRAME_GAP cycles (160+1024 = 1184 at defaults).
- All outputs are registered with no combinational path from input to output.

## Configuration
- CARET_BLINK_EN defined: frame counter present; o_caret_strobe toggles every BLINK_FRAMES frames.
- CARET_BLINK_EN undefined: no frame counter; o_caret_strobe is constant 1 (buffer never substitutes the caret). All other behaviour is identical.

## Test plan
- Reset, i_enable=1, defaults, buffer model returns 0x41+index → first READ at cycle 1024 after reset release. Each wr_n low pulse is exactly 4 cycles with data stable 2 cycles before and after. Index 5 → chip 1 addr 2 data 0x46.
- Read data 0x61, 0x7B, 0x1F, 0x5F → o_hpdl_data 0x41, 0x20, 0x20, 0x5F.
- Full frame → o_frame_done single pulse 160 cycles after the first READ. Next READ index 0 occurs 1024 cycles later. At no time is more than one wr_n bit low.
- i_enable dropped during STROBE of index 7 → the strobe completes its 4 cycles and HOLD runs. Then IDLE, with no index-8 READ. Re-enable → restarts at index 0.
- i_reset pulsed during STROBE → wr_n=4'hF in the same cycle and all outputs equal their reset values.
- CARET_BLINK_EN, BLINK_FRAMES=2, FRAME_GAP=4 → o_caret_strobe toggles 1→0 after frame 2 and 0→1 after frame 4. Without the macro it stays 1 throughout.

Source files
------------

// File: rtl/hpdl1414_scan_driver.sv
// hpdl1414_scan_driver: scans a 16-entry character buffer onto four HPDL-1414 displays.
// Optional macro CARET_BLINK_EN adds the frame counter that toggles o_caret_strobe.
module hpdl1414_scan_driver #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2,
    parameter int FRAME_GAP     = 1024,
    parameter int BLINK_FRAMES  = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    output logic       o_read_enable,
    output logic [3:0] o_read_address,
    input  logic [7:0] i_read_data,
    output logic       o_caret_strobe,
    output logic [6:0] o_hpdl_data,
    output logic [1:0] o_hpdl_addr,
    output logic [3:0] o_hpdl_wr_n,
    output logic       o_frame_done
);

    localparam int CMAX = (SETUP_CYCLES > STROBE_CYCLES)
                        ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                        : ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
    localparam int CW = $clog2(CMAX + 1);
    localparam int GW = $clog2(FRAME_GAP + 1);

    localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST    = GW'(FRAME_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    data_q, data_d;
    logic [1:0]    addr_q, addr_d;
    logic [3:0]    wr_n_q, wr_n_d;
    logic          rd_en_q, rd_en_d;
    logic          done_q, done_d;

    // Map a raw buffer byte onto the display's 7-bit character set.
    function automatic logic [6:0] sanitize(input logic [7:0] c);
        logic [6:0] r;
        unique case (1'b1)
            (c >= 8'h20 && c <= 8'h5F): r = c[6:0];
            (c >= 8'h61 && c <= 8'h7A): r = c[6:0] - 7'h20;
            default:                    r = 7'h20;
        endcase
        return r;
    endfunction

    // Next-state and next-output logic; every output is a flop below.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        addr_d  = addr_q;
        wr_n_d  = 4'hF;
        rd_en_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (gap_q == GAP_LAST) begin
                    if (i_enable) begin
                        state_d = S_READ;
                        rd_en_d = 1'b1;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_READ: state_d = S_CAPTURE;
            S_CAPTURE: begin
                data_d  = sanitize(i_read_data);
                addr_d  = 2'd3 - idx_q[1:0];
                cnt_d   = '0;
                state_d = S_SETUP;
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d              = '0;
                    state_d            = S_STROBE;
                    wr_n_d[idx_q[3:2]] = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d              = cnt_q + 1'b1;
                    wr_n_d[idx_q[3:2]] = 1'b0;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 4'd15 || !i_enable) begin
                        state_d = S_IDLE;
                        gap_d   = '0;
                        idx_d   = 4'd0;
                        done_d  = (idx_q == 4'd15);
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_READ;
                        rd_en_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scan state and registered display/buffer outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            gap_q   <= '0;
            cnt_q   <= '0;
            data_q  <= 7'd0;
            addr_q  <= 2'd0;
            wr_n_q  <= 4'hF;
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wr_n_q  <= wr_n_d;
            rd_en_q <= rd_en_d;
            done_q  <= done_d;
        end
    end

    assign o_read_enable  = rd_en_q;
    assign o_read_address = idx_q;
    assign o_hpdl_data    = data_q;
    assign o_hpdl_addr    = addr_q;
    assign o_hpdl_wr_n    = wr_n_q;
    assign o_frame_done   = done_q;

`ifdef CARET_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] frame_q, frame_d;
    logic          caret_q, caret_d;

    // Count finished frames; flip the caret phase every BLINK_FRAMES.
    always_comb begin
        frame_d = frame_q;
        caret_d = caret_q;
        if (done_d) begin
            if (frame_q == FRAME_LAST) begin
                frame_d = '0;
                caret_d = ~caret_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    // Caret blink state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            frame_q <= '0;
            caret_q <= 1'b1;
        end else begin
            frame_q <= frame_d;
            caret_q <= caret_d;
        end
    end

    assign o_caret_strobe = caret_q;
`else
    // Without blinking the caret is never shown; BLINK_FRAMES >= 1 so this is high.
    assign o_caret_strobe = (BLINK_FRAMES >= 1);
`endif

endmodule

// File: tb/tb_hpdl1414_scan_driver.sv
// tb_hpdl1414_scan_driver: directed checks of scan timing, sanitising,
// enable/reset behaviour, and caret blinking on a short-gap second instance.
module tb_hpdl1414_scan_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic       caret;
    logic [6:0] hdata;
    logic [1:0] haddr;
    logic [3:0] wr_n;
    logic       done;

    logic       rst_b = 1'b1;
    logic       rd_en_b;
    logic [3:0] rd_addr_b;
    logic [7:0] rd_data_b = 8'h00;
    logic       caret_b;
    logic [6:0] hdata_b;
    logic [1:0] haddr_b;
    logic [3:0] wr_n_b;
    logic       done_b;

    logic [7:0] buf_mem [16];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         multi_low = 0;
    int         nb = 0;
    logic       caret_hist [8];

    always #5 clk = ~clk;

    hpdl1414_scan_driver dut (
        .i_clk(clk), .i_reset(rst), .i_enable(en),
        .o_read_enable(rd_en), .o_read_address(rd_addr),
        .i_read_data(rd_data), .o_caret_strobe(caret),
        .o_hpdl_data(hdata), .o_hpdl_addr(haddr),
        .o_hpdl_wr_n(wr_n), .o_frame_done(done)
    );

    hpdl1414_scan_driver #(.FRAME_GAP(4), .BLINK_FRAMES(2)) dut_b (
        .i_clk(clk), .i_reset(rst_b), .i_enable(1'b1),
        .o_read_enable(rd_en_b), .o_read_address(rd_addr_b),
        .i_read_data(rd_data_b), .o_caret_strobe(caret_b),
        .o_hpdl_data(hdata_b), .o_hpdl_addr(haddr_b),
        .o_hpdl_wr_n(wr_n_b), .o_frame_done(done_b)
    );

    // Registered-read buffer models.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_data <= buf_mem[rd_addr];
        if (rd_en_b) rd_data_b <= 8'h41 + {4'h0, rd_addr_b};
    end

    always @(negedge clk) begin
        if (!$onehot0(~wr_n)) multi_low <= multi_low + 1;
        if (!rst_b && done_b) begin
            if (nb < 8) caret_hist[nb] <= caret_b;
            nb <= nb + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_rd(input int limit, output int t);
        t = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (rd_en) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_data"}, hdata, 0);
        check({tag, "_addr"}, haddr, 0);
        check({tag, "_wr_n"}, wr_n, 4'hF);
        check({tag, "_done"}, done, 0);
        check({tag, "_caret"}, caret, 1);
    endtask

    // Called at the READ cycle of index k; returns at the following cycle.
    task automatic run_char(input int k, input logic [6:0] exp_d,
                            input bit drop_en);
        logic [3:0] mask;
        logic [1:0] ea;
        int bad;
        int lows;
        mask = 4'hF;
        mask[k / 4] = 1'b0;
        ea = 2'(3 - (k % 4));
        bad = 0;
        lows = 0;
        check($sformatf("rd_addr%0d", k), rd_addr, k);
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (hdata !== exp_d || haddr !== ea) bad++;
            if (wr_n !== ((c >= 2 && c <= 5) ? mask : 4'hF)) bad++;
            if (wr_n === mask) lows++;
            if (drop_en && c == 3) en = 1'b0;
        end
        check($sformatf("data%0d", k), hdata, exp_d);
        check($sformatf("digit%0d", k), haddr, ea);
        check($sformatf("wr_width%0d", k), lows, 4);
        check($sformatf("timing%0d", k), bad, 0);
        @(negedge clk);
    endtask

    initial begin
        int t0;
        int t;
        int cnt;
        logic [6:0] exp2 [8];
        for (int i = 0; i < 16; i++) buf_mem[i] = 8'h41 + 8'(i);
        exp2[0] = 7'h41; exp2[1] = 7'h20; exp2[2] = 7'h20; exp2[3] = 7'h5F;
        exp2[4] = 7'h20; exp2[5] = 7'h5A; exp2[6] = 7'h20; exp2[7] = 7'h40;

        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        check("rst_caret_b", caret_b, 1);
        rst = 1'b0;
        rst_b = 1'b0;
        t0 = cyc;

        wait_rd(2000, t);
        check("first_read", t - t0, 1024);
        t0 = t;
        for (int k = 0; k < 16; k++) run_char(k, 7'(8'h41 + 8'(k)), 1'b0);
        check("done_pulse", done, 1);
        check("done_time", cyc - t0, 160);
        t0 = cyc;
        @(negedge clk);
        check("done_single", done, 0);

        buf_mem[0] = 8'h61; buf_mem[1] = 8'h7B; buf_mem[2] = 8'h1F;
        buf_mem[3] = 8'h5F; buf_mem[4] = 8'h60; buf_mem[5] = 8'h7A;
        buf_mem[6] = 8'hFF; buf_mem[7] = 8'h40;
        wait_rd(2000, t);
        check("gap_time", t - t0, 1024);
        for (int k = 0; k < 8; k++) run_char(k, exp2[k], k == 7);

        check("idle_no_read", rd_en, 0);
        check("idle_index", rd_addr, 0);
        cnt = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (rd_en || done) cnt++;
        end
        check("disabled_quiet", cnt, 0);
        en = 1'b1;
        t0 = cyc;
        wait_rd(50, t);
        check("reenable_time", t - t0, 1);
        check("reenable_index", rd_addr, 0);

        repeat (4) @(negedge clk);
        check("mid_strobe_wr", wr_n, 4'hE);
        #1 rst = 1'b1;
        #1 check_reset_vals("async");
        @(negedge clk);
        check_reset_vals("held");
        rst = 1'b0;
        t0 = cyc;
        wait_rd(2000, t);
        check("post_rst_read", t - t0, 1024);
        check("post_rst_index", rd_addr, 0);

        check("one_wr_low", multi_low, 0);
        check("b_frames", nb >= 4, 1);
`ifdef CARET_BLINK_EN
        check("caret_f1", caret_hist[0], 1);
        check("caret_f2", caret_hist[1], 0);
        check("caret_f3", caret_hist[2], 0);
        check("caret_f4", caret_hist[3], 1);
`else
        check("caret_f1", caret_hist[0], 1);
        check("caret_f2", caret_hist[1], 1);
        check("caret_f3", caret_hist[2], 1);
        check("caret_f4", caret_hist[3], 1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
